// File: rtl/lsm_pkg.sv
// Shared definitions for the load/store-multiple sequencer:
// command codes, FSM states and addressing-mode encodings.
package lsm_pkg;

  // Commands from the LSM_IN2..LSM_IN0 control-word field
  localparam logic [2:0] LSM_HOLD  = 3'b000;
  localparam logic [2:0] LSM_LOAD  = 3'b001;
  localparam logic [2:0] LSM_NEXT  = 3'b010;
  localparam logic [2:0] LSM_ABORT = 3'b100;

  // Addressing modes, encoded as {P, U} taken from IR[24:23]
  localparam logic [1:0] IA = 2'b01;
  localparam logic [1:0] IB = 2'b11;
  localparam logic [1:0] DA = 2'b00;
  localparam logic [1:0] DB = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/lsm_sequencer_if.sv
// Bus between the control unit / datapath (master) and the LSM sequencer (slave).
interface lsm_sequencer_if;

  logic [31:0] IR;
  logic        LSM_EN;
  logic [2:0]  LSM_IN;
  logic        LSM_DETECT;
  logic        LSM_END;
  logic [3:0]  REG_NUM;
  logic [4:0]  COUNT;
  logic [7:0]  START_OFF;
  logic [7:0]  WB_OFF;
  logic        BUSY;

  modport master (
    output IR, LSM_EN, LSM_IN,
    input  LSM_DETECT, LSM_END, REG_NUM, COUNT, START_OFF, WB_OFF, BUSY
  );

  modport slave (
    input  IR, LSM_EN, LSM_IN,
    output LSM_DETECT, LSM_END, REG_NUM, COUNT, START_OFF, WB_OFF, BUSY
  );

endinterface

// File: rtl/lsm_prio_enc.sv
// 16-to-4 priority encoder; the lowest set bit wins, index is 0 when nothing is set.
module lsm_prio_enc (
  input  logic [15:0] req_i,
  output logic [3:0]  idx_o,
  output logic        valid_o
);

  // Scan from the top down so the lowest set bit is the last one written
  always_comb begin
    idx_o   = 4'd0;
    valid_o = 1'b0;
    for (int i = 15; i >= 0; i--) begin
      if (req_i[i]) begin
        idx_o   = 4'(i);
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lsm_sequencer.sv
// Load/store-multiple sequencer: latches an LDM/STM register list, walks it
// lowest register first and reports progress plus address offsets.
module lsm_sequencer
  import lsm_pkg::*;
(
  input  logic          CLK,
  input  logic          RST,
  lsm_sequencer_if.slave bus
);

  state_t      state_q, state_d;
  logic [15:0] list_q, list_d;
  logic        p_q, p_d;
  logic        u_q, u_d;
  logic [4:0]  count_q, count_d;

  logic [2:0]  cmd;
  logic [3:0]  regNum;
  logic        regValid;
  logic        lastReg;
  logic [4:0]  loadCount;
  logic [7:0]  fourN;
  logic [7:0]  negFourN;
  logic [7:0]  startOff;
  logic [7:0]  wbOff;
  logic        unusedIr;

  // Without the qualifier every command collapses to HOLD
  assign cmd = bus.LSM_EN ? bus.LSM_IN : LSM_HOLD;

  // Only P, U and the register list are meaningful here
  assign unusedIr = ^{bus.IR[31:25], bus.IR[22:16]};

  lsm_prio_enc u_prio_enc (
    .req_i   (list_q),
    .idx_o   (regNum),
    .valid_o (regValid)
  );

  // Exactly one bit left: clearing the lowest set bit leaves nothing
  assign lastReg = regValid && ((list_q & (list_q - 16'd1)) == 16'd0);

  // Population count of the incoming list, captured as COUNT on LOAD
  always_comb begin
    loadCount = 5'd0;
    for (int i = 0; i < 16; i++) begin
      loadCount = loadCount + {4'd0, bus.IR[i]};
    end
  end

  // FSM state register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next-state: LOAD restarts from any state, NEXT only advances in ACTIVE
  always_comb begin
    state_d = state_q;
    case (cmd)
      LSM_LOAD:  state_d = (bus.IR[15:0] != 16'd0) ? ACTIVE : DONE;
      LSM_NEXT:  if (state_q == ACTIVE && lastReg) state_d = DONE;
      LSM_ABORT: state_d = IDLE;
      default:   state_d = state_q;
    endcase
  end

  // Next values for the list, addressing mode and count
  always_comb begin
    list_d  = list_q;
    p_d     = p_q;
    u_d     = u_q;
    count_d = count_q;
    case (cmd)
      LSM_LOAD: begin
        list_d  = bus.IR[15:0];
        p_d     = bus.IR[24];
        u_d     = bus.IR[23];
        count_d = loadCount;
      end
      LSM_NEXT: begin
        if (state_q == ACTIVE) list_d = list_q & ~(16'd1 << regNum);
      end
      LSM_ABORT: begin
        list_d  = 16'd0;
        p_d     = 1'b0;
        u_d     = 1'b0;
        count_d = 5'd0;
      end
      default: list_d = list_q;
    endcase
  end

  // Datapath registers holding the captured instruction fields
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      list_q  <= 16'd0;
      p_q     <= 1'b0;
      u_q     <= 1'b0;
      count_q <= 5'd0;
    end else begin
      list_q  <= list_d;
      p_q     <= p_d;
      u_q     <= u_d;
      count_q <= count_d;
    end
  end

  assign fourN    = {1'b0, count_q, 2'b00};
  assign negFourN = 8'd0 - fourN;

  // FSM outputs: offsets are forced to zero in IDLE so reset/abort read as 0
  always_comb begin
    startOff = 8'd0;
    wbOff    = 8'd0;
    if (state_q != IDLE) begin
      case ({p_q, u_q})
        IA:      startOff = 8'd0;
        IB:      startOff = 8'd4;
        DA:      startOff = negFourN + 8'd4;
        default: startOff = negFourN;
      endcase
      wbOff = u_q ? fourN : negFourN;
    end
  end

  assign bus.LSM_DETECT = regValid;
  assign bus.LSM_END    = lastReg;
  assign bus.REG_NUM    = regNum;
  assign bus.COUNT      = count_q;
  assign bus.START_OFF  = startOff;
  assign bus.WB_OFF     = wbOff;
  assign bus.BUSY       = (state_q == ACTIVE);

endmodule

// File: tb/tb_lsm_sequencer.sv
// Directed, table-driven bench for the LSM sequencer plus hand sequences
// for the full-list walk and asynchronous reset.
module tb_lsm_sequencer;
  import lsm_pkg::*;

  typedef struct {
    logic        en;
    logic [2:0]  cmd;
    logic [31:0] ir;
    logic        det;
    logic        lend;
    logic [3:0]  regNum;
    logic [4:0]  cnt;
    logic [7:0]  so;
    logic [7:0]  wb;
    logic        busy;
  } vec_t;

  localparam int NVEC = 23;

  logic CLK;
  logic RST;
  int   checks;
  int   failures;
  vec_t vecs [NVEC];

  lsm_sequencer_if bus ();

  lsm_sequencer dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  // 10-unit clock period
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic vec_t mkVec(logic en, logic [2:0] cmd, logic [31:0] ir,
                                 logic det, logic lend, logic [3:0] regNum,
                                 logic [4:0] cnt, logic [7:0] so, logic [7:0] wb,
                                 logic busy);
    vec_t v;
    v.en = en; v.cmd = cmd; v.ir = ir;
    v.det = det; v.lend = lend; v.regNum = regNum;
    v.cnt = cnt; v.so = so; v.wb = wb; v.busy = busy;
    return v;
  endfunction

  // Drive a command at the falling edge; return 1 unit after the sampling edge
  task automatic applyStimulus(input logic en, input logic [2:0] cmd, input logic [31:0] ir);
    @(negedge CLK);
    bus.LSM_EN = en;
    bus.LSM_IN = cmd;
    bus.IR     = ir;
    @(posedge CLK);
    #1;
  endtask

  task automatic checkField(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic checkOutput(input string tag, input logic det, input logic lend,
                             input logic [3:0] regNum, input logic [4:0] cnt,
                             input logic [7:0] so, input logic [7:0] wb, input logic busy);
    checkField({tag, ".LSM_DETECT"}, 32'(bus.LSM_DETECT), 32'(det));
    checkField({tag, ".LSM_END"},    32'(bus.LSM_END),    32'(lend));
    checkField({tag, ".REG_NUM"},    32'(bus.REG_NUM),    32'(regNum));
    checkField({tag, ".COUNT"},      32'(bus.COUNT),      32'(cnt));
    checkField({tag, ".START_OFF"},  32'(bus.START_OFF),  32'(so));
    checkField({tag, ".WB_OFF"},     32'(bus.WB_OFF),     32'(wb));
    checkField({tag, ".BUSY"},       32'(bus.BUSY),       32'(busy));
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    //                en    cmd        ir             det  end  reg    cnt    so      wb      busy
    vecs[0]  = mkVec(1'b1, LSM_LOAD,  32'h0080_8005, 1'b1, 1'b0, 4'd0,  5'd3,  8'h00, 8'h0C, 1'b1); // IA 0x8005
    vecs[1]  = mkVec(1'b1, LSM_NEXT,  32'h0000_0000, 1'b1, 1'b0, 4'd2,  5'd3,  8'h00, 8'h0C, 1'b1);
    vecs[2]  = mkVec(1'b0, LSM_NEXT,  32'h0000_0000, 1'b1, 1'b0, 4'd2,  5'd3,  8'h00, 8'h0C, 1'b1); // unqualified
    vecs[3]  = mkVec(1'b1, 3'b011,    32'h0000_0000, 1'b1, 1'b0, 4'd2,  5'd3,  8'h00, 8'h0C, 1'b1);
    vecs[4]  = mkVec(1'b1, 3'b101,    32'h0000_0000, 1'b1, 1'b0, 4'd2,  5'd3,  8'h00, 8'h0C, 1'b1);
    vecs[5]  = mkVec(1'b1, 3'b110,    32'h0000_0000, 1'b1, 1'b0, 4'd2,  5'd3,  8'h00, 8'h0C, 1'b1);
    vecs[6]  = mkVec(1'b1, 3'b111,    32'h0000_0000, 1'b1, 1'b0, 4'd2,  5'd3,  8'h00, 8'h0C, 1'b1);
    vecs[7]  = mkVec(1'b1, LSM_NEXT,  32'h0000_0000, 1'b1, 1'b1, 4'd15, 5'd3,  8'h00, 8'h0C, 1'b1);
    vecs[8]  = mkVec(1'b1, LSM_NEXT,  32'h0000_0000, 1'b0, 1'b0, 4'd0,  5'd3,  8'h00, 8'h0C, 1'b0); // DONE
    vecs[9]  = mkVec(1'b1, LSM_NEXT,  32'h0000_0000, 1'b0, 1'b0, 4'd0,  5'd3,  8'h00, 8'h0C, 1'b0); // ignored
    vecs[10] = mkVec(1'b1, LSM_LOAD,  32'h0100_00F0, 1'b1, 1'b0, 4'd4,  5'd4,  8'hF0, 8'hF0, 1'b1); // DB
    vecs[11] = mkVec(1'b1, LSM_LOAD,  32'h0000_00F0, 1'b1, 1'b0, 4'd4,  5'd4,  8'hF4, 8'hF0, 1'b1); // DA
    vecs[12] = mkVec(1'b1, LSM_NEXT,  32'h0000_0000, 1'b1, 1'b0, 4'd5,  5'd4,  8'hF4, 8'hF0, 1'b1);
    vecs[13] = mkVec(1'b1, LSM_LOAD,  32'h0180_0300, 1'b1, 1'b0, 4'd8,  5'd2,  8'h04, 8'h08, 1'b1); // IB restart
    vecs[14] = mkVec(1'b1, LSM_ABORT, 32'h0000_0000, 1'b0, 1'b0, 4'd0,  5'd0,  8'h00, 8'h00, 1'b0);
    vecs[15] = mkVec(1'b1, LSM_NEXT,  32'h0000_0000, 1'b0, 1'b0, 4'd0,  5'd0,  8'h00, 8'h00, 1'b0); // IDLE
    vecs[16] = mkVec(1'b1, LSM_LOAD,  32'h0080_0000, 1'b0, 1'b0, 4'd0,  5'd0,  8'h00, 8'h00, 1'b0); // empty IA
    vecs[17] = mkVec(1'b1, LSM_LOAD,  32'h0180_0000, 1'b0, 1'b0, 4'd0,  5'd0,  8'h04, 8'h00, 1'b0); // empty IB
    vecs[18] = mkVec(1'b1, LSM_LOAD,  32'hFEFF_4000, 1'b1, 1'b1, 4'd14, 5'd1,  8'h00, 8'h04, 1'b1); // junk IR bits
    vecs[19] = mkVec(1'b1, LSM_HOLD,  32'h0000_FFFF, 1'b1, 1'b1, 4'd14, 5'd1,  8'h00, 8'h04, 1'b1); // IR changes
    vecs[20] = mkVec(1'b0, LSM_LOAD,  32'h0000_FFFF, 1'b1, 1'b1, 4'd14, 5'd1,  8'h00, 8'h04, 1'b1); // unqualified
    vecs[21] = mkVec(1'b1, LSM_NEXT,  32'h0000_0000, 1'b0, 1'b0, 4'd0,  5'd1,  8'h00, 8'h04, 1'b0);
    vecs[22] = mkVec(1'b1, LSM_ABORT, 32'h0000_0000, 1'b0, 1'b0, 4'd0,  5'd0,  8'h00, 8'h00, 1'b0);

    bus.LSM_EN = 1'b0;
    bus.LSM_IN = LSM_HOLD;
    bus.IR     = 32'h0;
    RST        = 1'b1;
    #12;
    checkOutput("reset", 1'b0, 1'b0, 4'd0, 5'd0, 8'h00, 8'h00, 1'b0);
    @(negedge CLK);
    RST = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i].en, vecs[i].cmd, vecs[i].ir);
      checkOutput($sformatf("vec%0d", i), vecs[i].det, vecs[i].lend, vecs[i].regNum,
                  vecs[i].cnt, vecs[i].so, vecs[i].wb, vecs[i].busy);
    end

    // Full list in DA mode: -4*16+4 = -60, writeback -64
    applyStimulus(1'b1, LSM_LOAD, 32'h0000_FFFF);
    checkOutput("full.load", 1'b1, 1'b0, 4'd0, 5'd16, 8'hC4, 8'hC0, 1'b1);
    for (int k = 1; k <= 15; k++) begin
      applyStimulus(1'b1, LSM_NEXT, 32'h0);
      checkOutput($sformatf("full.next%0d", k), 1'b1, (k == 15), 4'(k), 5'd16, 8'hC4, 8'hC0, 1'b1);
    end
    applyStimulus(1'b1, LSM_NEXT, 32'h0);
    checkOutput("full.next16", 1'b0, 1'b0, 4'd0, 5'd16, 8'hC4, 8'hC0, 1'b0);

    // Asynchronous reset in the middle of a walk, between clock edges
    applyStimulus(1'b1, LSM_LOAD, 32'h0080_8005);
    applyStimulus(1'b1, LSM_NEXT, 32'h0);
    checkOutput("pre_rst", 1'b1, 1'b0, 4'd2, 5'd3, 8'h00, 8'h0C, 1'b1);
    bus.LSM_EN = 1'b0;
    #2;
    RST = 1'b1;
    #1;
    checkOutput("async_rst", 1'b0, 1'b0, 4'd0, 5'd0, 8'h00, 8'h00, 1'b0);
    @(negedge CLK);
    RST = 1'b0;
    applyStimulus(1'b1, LSM_LOAD, 32'h0100_00F0);
    checkOutput("post_rst", 1'b1, 1'b0, 4'd4, 5'd4, 8'hF0, 8'hF0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
